// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared opcode/phase constants for the simple RISC controller
//
// Widths, the fixed 3-bit opcode map and the 8 instruction-cycle phase codes.
// No ports.

package risc_pkg;

    localparam int OPW = 3;
    localparam int PHW = 3;

    localparam logic [OPW-1:0] OP_HLT = 3'd0;
    localparam logic [OPW-1:0] OP_SKZ = 3'd1;
    localparam logic [OPW-1:0] OP_ADD = 3'd2;
    localparam logic [OPW-1:0] OP_AND = 3'd3;
    localparam logic [OPW-1:0] OP_XOR = 3'd4;
    localparam logic [OPW-1:0] OP_LDA = 3'd5;
    localparam logic [OPW-1:0] OP_STO = 3'd6;
    localparam logic [OPW-1:0] OP_JMP = 3'd7;

    localparam logic [PHW-1:0] PH_INST_ADDR  = 3'd0;
    localparam logic [PHW-1:0] PH_INST_FETCH = 3'd1;
    localparam logic [PHW-1:0] PH_INST_LOAD  = 3'd2;
    localparam logic [PHW-1:0] PH_IDLE       = 3'd3;
    localparam logic [PHW-1:0] PH_OP_ADDR    = 3'd4;
    localparam logic [PHW-1:0] PH_OP_FETCH   = 3'd5;
    localparam logic [PHW-1:0] PH_ALU_OP     = 3'd6;
    localparam logic [PHW-1:0] PH_STORE      = 3'd7;

    // Opcodes that read an operand from memory into the accumulator path.
    function automatic logic is_aluop(input logic [OPW-1:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/ctrl_phase_counter.sv
// rtl/ctrl_phase_counter.sv - wrapping instruction-phase counter with enable and hold
//
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-low reset, clears the count
//   ena   - advance enable
//   hold  - freezes the count even when enabled (halt / single-step wait)
//   count - current phase

module ctrl_phase_counter #(
    parameter int PHW = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ena,
    input  logic           hold,
    output logic [PHW-1:0] count
);

    logic [PHW-1:0] count_q;
    logic [PHW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (ena && !hold) begin
            // Natural overflow gives the 7 -> 0 wrap.
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/risc_controller.sv
// rtl/risc_controller.sv - 8-phase instruction sequencer for the 8-bit simple RISC core
//
// Ports:
//   clk, rst (sync active-low), ena (advance enable / strobe gate)
//   opcode (IR opcode), zero (ALU zero flag)
//   step (only with SINGLE_STEP_EN: releases the next instruction)
//   sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt - datapath controls
//
// Optional feature macro: SINGLE_STEP_EN

import risc_pkg::*;

module risc_controller #(
    parameter int OPW = 3,
    parameter int PHW = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ena,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
`ifdef SINGLE_STEP_EN
    input  logic           step,
`endif
    output logic           sel,
    output logic           rd,
    output logic           wr,
    output logic           ld_ir,
    output logic           ld_ac,
    output logic           ld_pc,
    output logic           inc_pc,
    output logic           data_e,
    output logic           halt
);

    logic [PHW-1:0] phase;
    logic           halted_q;
    logic           halted_d;
    logic           set_halt;
    logic           step_hold;
    logic           hold;
    logic           aluop;

    // HLT is taken on the edge that ends phase 4; the phase must not advance on
    // that same edge, so the set condition also feeds the counter hold.
    assign set_halt = ena && !halted_q && (phase == PH_OP_ADDR) && (opcode == OP_HLT);
    assign halted_d = halted_q | set_halt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

`ifdef SINGLE_STEP_EN
    logic wait_q;
    logic wait_d;
    logic wrap;

    assign wrap      = ena && !hold && (phase == PH_STORE);
    // Only phase 0 ever waits; step is don't-care once an instruction is running.
    assign step_hold = wait_q && (phase == PH_INST_ADDR) && !step;

    always_comb begin
        wait_d = wait_q;
        if (wrap) begin
            wait_d = 1'b1;
        end else if (wait_q && (phase == PH_INST_ADDR) && ena && step) begin
            wait_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_q <= 1'b1;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    assign step_hold = 1'b0;
`endif

    assign hold = halted_q | set_halt | step_hold;

    ctrl_phase_counter #(
        .PHW (PHW)
    ) u_phase (
        .clk   (clk),
        .rst   (rst),
        .ena   (ena),
        .hold  (hold),
        .count (phase)
    );

    assign aluop = is_aluop(opcode);

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        wr     = 1'b0;
        ld_ir  = 1'b0;
        ld_ac  = 1'b0;
        ld_pc  = 1'b0;
        inc_pc = 1'b0;
        data_e = 1'b0;
        halt   = 1'b0;

        if (halted_q) begin
            halt = 1'b1;
        end else begin
            case (phase)
                PH_INST_ADDR: begin
                    sel = 1'b1;
                end
                PH_INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                PH_INST_LOAD, PH_IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                PH_OP_ADDR: begin
                    // PC still steps past HLT in the cycle that halts.
                    inc_pc = 1'b1;
                    halt   = (opcode == OP_HLT);
                end
                PH_OP_FETCH: begin
                    rd = aluop;
                end
                PH_ALU_OP: begin
                    rd     = aluop;
                    inc_pc = (opcode == OP_SKZ) && zero;
                    ld_pc  = (opcode == OP_JMP);
                    data_e = (opcode == OP_STO);
                end
                PH_STORE: begin
                    rd     = aluop;
                    ld_ac  = aluop;
                    ld_pc  = (opcode == OP_JMP);
                    wr     = (opcode == OP_STO);
                    data_e = (opcode == OP_STO);
                end
                default: begin
                    sel = 1'b0;
                end
            endcase

            // A stalled cycle must not commit anything; sel/halt are pure status.
            if (!ena) begin
                rd     = 1'b0;
                wr     = 1'b0;
                ld_ir  = 1'b0;
                ld_ac  = 1'b0;
                ld_pc  = 1'b0;
                inc_pc = 1'b0;
                data_e = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_risc_controller.sv
// tb/tb_risc_controller.sv - self-checking bench for risc_controller against a cycle reference model

module tb_risc_controller;

`ifdef SINGLE_STEP_EN
    localparam bit SS = 1'b1;
`else
    localparam bit SS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [2:0] opcode;
    logic       zero;
    logic       step_i;
    logic       sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: which phase of the instruction we are in, halted, waiting for step.
    int m_phase = 0;
    bit m_halt  = 1'b0;
    bit m_wait  = 1'b0;

    logic [8:0] obs;

    always #5 clk = ~clk;

    risc_controller dut (
        .clk    (clk),
        .rst    (rst),
        .ena    (ena),
        .opcode (opcode),
        .zero   (zero),
`ifdef SINGLE_STEP_EN
        .step   (step_i),
`endif
        .sel    (sel),
        .rd     (rd),
        .wr     (wr),
        .ld_ir  (ld_ir),
        .ld_ac  (ld_ac),
        .ld_pc  (ld_pc),
        .inc_pc (inc_pc),
        .data_e (data_e),
        .halt   (halt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected {sel,rd,wr,ld_ir,ld_ac,ld_pc,inc_pc,data_e,halt} from the instruction-cycle rules.
    function automatic logic [8:0] model_out(input bit e, input int op, input bit z);
        bit alu, s, r, w, li, la, lp, ip, de, h;
        alu = (op == 2) || (op == 3) || (op == 4) || (op == 5);
        if (m_halt) return 9'b0_0000_0001;
        s  = (m_phase <= 3);
        r  = (m_phase >= 1 && m_phase <= 3) || (m_phase >= 5 && alu);
        li = (m_phase == 2) || (m_phase == 3);
        ip = (m_phase == 4) || (m_phase == 6 && op == 1 && z);
        lp = (m_phase >= 6) && (op == 7);
        de = (m_phase >= 6) && (op == 6);
        w  = (m_phase == 7) && (op == 6);
        la = (m_phase == 7) && alu;
        h  = (m_phase == 4) && (op == 0);
        if (!e) begin
            r = 0; w = 0; li = 0; la = 0; lp = 0; ip = 0; de = 0;
        end
        return {s, r, w, li, la, lp, ip, de, h};
    endfunction

    task automatic cyc(input bit r, input bit e, input int op, input bit z, input bit s, input bit chk);
        rst    = r;
        ena    = e;
        opcode = op[2:0];
        zero   = z;
        step_i = s;
        #1;
        obs = {sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt};
        if (chk) check($sformatf("outs ph%0d op%0d ena%0d hlt%0d", m_phase, op, e, m_halt),
                       {23'd0, obs}, {23'd0, model_out(e, op, z)});
        @(posedge clk);
        if (!r) begin
            m_phase = 0;
            m_halt  = 1'b0;
            m_wait  = SS;
        end else if (e && !m_halt) begin
            if (m_phase == 4 && op == 0) begin
                m_halt = 1'b1;
            end else if (m_phase == 0 && m_wait) begin
                if (s) begin
                    m_wait  = 1'b0;
                    m_phase = 1;
                end
            end else if (m_phase == 7) begin
                m_phase = 0;
                m_wait  = SS;
            end else begin
                m_phase = m_phase + 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic run_instr(input int op, input bit z);
        for (int i = 0; i < 8; i++) cyc(1, 1, op, z, 1, 1);
    endtask

    initial begin
        int cnt;
        int op_r;
        bit r_r, e_r;

        // Reset with ena high; the first cycle's outputs are still undefined.
        cyc(0, 1, 2, 0, 0, 0);
        cyc(0, 1, 2, 0, 0, 1);
        check("reset_outs", {23'd0, obs}, 32'h100);

        // Directed instructions from phase 0.
        run_instr(2, 0);
        run_instr(6, 0);
        run_instr(1, 1);
        run_instr(1, 0);
        run_instr(7, 0);

        // LDA stalled 3 cycles in phase 5: ld_ac must land in the 11th cycle.
        cnt = 0;
        for (int i = 0; i < 11; i++) begin
            cyc(1, !(i >= 5 && i < 8), 5, 0, 1, 1);
            if (obs[4] && cnt == 0) cnt = i + 1;
        end
        check("lda_stall_latency", cnt, 11);

        // HLT: halt in phase 4 plus 20 sticky cycles, then a one-cycle reset.
        cnt = 0;
        for (int i = 0; i < 25; i++) begin
            cyc(1, 1, 0, $urandom_range(0, 1), 1, 1);
            if (obs[0]) cnt++;
        end
        check("hlt_sticky_cycles", cnt, 21);
        cyc(0, 1, 0, 0, 0, 1);
        cyc(1, 1, 2, 0, 1, 1);
        check("after_hlt_reset", {23'd0, obs}, 32'h100);

        // Finish the instruction so phase returns to 0.
        for (int i = 0; i < 7; i++) cyc(1, 1, 2, 0, 1, 1);

`ifdef SINGLE_STEP_EN
        cyc(0, 1, 2, 0, 0, 1);
        for (int i = 0; i < 5; i++) cyc(1, 1, 2, 0, 0, 1);
        check("step_wait_sel", {31'd0, obs[8]}, 32'd1);
        cnt = 0;
        cyc(1, 1, 2, 0, 1, 1);
        for (int i = 0; i < 12; i++) begin
            cyc(1, 1, 2, 0, 0, 1);
            if (obs[5]) cnt++;
        end
        check("step_one_instr_ldir", cnt, 2);
`endif

        // Randomized traffic against the model.
        op_r = 2;
        for (int i = 0; i < 2000; i++) begin
            if (m_phase == 0) begin
                op_r = ($urandom_range(0, 39) == 0) ? 0 : $urandom_range(1, 7);
            end
            r_r = !(m_halt ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 199) == 0));
            e_r = ($urandom_range(0, 4) != 0);
            cyc(r_r, e_r, op_r, $urandom_range(0, 1), ($urandom_range(0, 2) == 0), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
